// File: rtl/pattern_serializer.sv
// pattern_serializer: shifts WIDTH-bit words accepted on load_valid/load_ready out on x_out/x_valid one bit per clk, pulsing done after each word's last bit; busy marks SHIFT; reset is async active-high
module pattern_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             x_out,
  output logic             x_valid,
  output logic             done,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0] cnt;
  logic accept, last;
  assign last   = state == SHIFT && cnt == CW'(1);
  assign accept = load_valid && load_ready;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb state_nx = accept ? SHIFT : last ? IDLE : state;
  always_comb load_ready = state == IDLE || cnt == CW'(1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sr      <= '0;
      cnt     <= '0;
      x_out   <= IDLE_LEVEL;
      x_valid <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      done <= last;
      if (accept) begin
        x_out   <= MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
        sr      <= MSB_FIRST ? data_in << 1 : data_in >> 1;
        cnt     <= CW'(WIDTH);
        x_valid <= 1'b1;
        busy    <= 1'b1;
      end else if (last) begin
        x_out   <= IDLE_LEVEL;
        sr      <= '0;
        cnt     <= '0;
        x_valid <= 1'b0;
        busy    <= 1'b0;
      end else if (state == SHIFT) begin
        x_out <= MSB_FIRST ? sr[WIDTH-1] : sr[0];
        sr    <= MSB_FIRST ? sr << 1 : sr >> 1;
        cnt   <= cnt - CW'(1);
      end
    end
endmodule

// File: tb/tb_pattern_serializer.sv
// tb_pattern_serializer: scoreboard bench driving MSB-first and LSB-first serializers with shared stimulus
module tb_pattern_serializer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] data_in = '0;
  logic load_valid = 1'b0;
  logic rdy[2], xo[2], xv[2], dn[2], bz[2];
  bit q[2][$];
  int pos[2];
  bit pend[2];
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  pattern_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
    .clk(clk), .reset(reset), .data_in(data_in), .load_valid(load_valid),
    .load_ready(rdy[0]), .x_out(xo[0]), .x_valid(xv[0]), .done(dn[0]), .busy(bz[0]));
  pattern_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .data_in(data_in), .load_valid(load_valid),
    .load_ready(rdy[1]), .x_out(xo[1]), .x_valid(xv[1]), .done(dn[1]), .busy(bz[1]));
  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    for (int d = 0; d < 2; d++)
      if (reset) begin
        pos[d] = 0;
        pend[d] = 1'b0;
      end else begin
        chk($sformatf("done[%0d]", d), dn[d], pend[d]);
        if (q[d].size() > 0) begin
          chk($sformatf("x_valid[%0d]", d), xv[d], 1'b1);
          chk($sformatf("busy[%0d]", d), bz[d], 1'b1);
          chk($sformatf("x_out[%0d]", d), xo[d], q[d].pop_front());
          pos[d]++;
          pend[d] = pos[d] == 8;
          if (pos[d] == 8) pos[d] = 0;
          chk($sformatf("load_ready_shift[%0d]", d), rdy[d], pend[d]);
        end else begin
          chk($sformatf("x_valid_idle[%0d]", d), xv[d], 1'b0);
          chk($sformatf("busy_idle[%0d]", d), bz[d], 1'b0);
          chk($sformatf("x_out_idle[%0d]", d), xo[d], 1'b0);
          chk($sformatf("load_ready_idle[%0d]", d), rdy[d], 1'b1);
          pend[d] = 1'b0;
        end
      end
  task automatic push_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      q[0].push_back(w[7-i]);
      q[1].push_back(w[i]);
    end
  endtask
  task automatic step(input logic lv, input logic [7:0] d, output bit acc);
    load_valid = lv;
    data_in = d;
    @(negedge clk);
    acc = load_valid && rdy[0];
    @(posedge clk);
    if (acc) push_word(data_in);
    #1;
  endtask
  task automatic send(input logic [7:0] w);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 40) begin
      step(1'b1, w, acc);
      n++;
    end
    if (!acc) chk("send_timeout", 1'b0, 1'b1);
  endtask
  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, acc);
  endtask
  initial begin
    bit acc;
    #12;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_x_out[%0d]", d), xo[d], 1'b0);
      chk($sformatf("rst_x_valid[%0d]", d), xv[d], 1'b0);
      chk($sformatf("rst_busy[%0d]", d), bz[d], 1'b0);
      chk($sformatf("rst_done[%0d]", d), dn[d], 1'b0);
      chk($sformatf("rst_ready[%0d]", d), rdy[d], 1'b1);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    send(8'hD6);
    idle(11);
    send(8'hFF);
    send(8'h00);
    idle(11);
    send(8'hA5);
    step(1'b0, 8'hA5, acc);
    step(1'b0, 8'hA5, acc);
    #1;
    reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("async_x_out[%0d]", d), xo[d], 1'b0);
      chk($sformatf("async_x_valid[%0d]", d), xv[d], 1'b0);
      chk($sformatf("async_busy[%0d]", d), bz[d], 1'b0);
      chk($sformatf("async_done[%0d]", d), dn[d], 1'b0);
    end
    q[0].delete();
    q[1].delete();
    @(posedge clk);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
    send(8'h3C);
    idle(11);
    send(8'hC0);
    step(1'b0, 8'hC0, acc);
    step(1'b1, 8'h0F, acc);
    step(1'b0, 8'h0F, acc);
    step(1'b1, 8'h0F, acc);
    idle(10);
    for (int i = 0; i < 600; i++) step($urandom_range(0, 3) != 0, 8'($urandom), acc);
    idle(12);
    chk("drain_msb", q[0].size() == 0, 1'b1);
    chk("drain_lsb", q[1].size() == 0, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
